// File: rtl/core_pkg.sv
//==============================================================================
// Package  : core_pkg
// Desc     : Shared ALU op codes, divider state encoding and constants.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package core_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd11;
    localparam logic [4:0] ALU_MULH   = 5'd12;
    localparam logic [4:0] ALU_MULHSU = 5'd13;
    localparam logic [4:0] ALU_MULHU  = 5'd14;
    localparam logic [4:0] ALU_DIV    = 5'd15;
    localparam logic [4:0] ALU_DIVU   = 5'd16;
    localparam logic [4:0] ALU_REM    = 5'd17;
    localparam logic [4:0] ALU_REMU   = 5'd18;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    localparam logic [31:0] DIV_OVF_Q = 32'h8000_0000;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_divider.sv
//==============================================================================
// Module   : ex_divider
// Desc     : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_divider
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            ack,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [4:0]      r_count;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_result;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_is_rem;

    logic            w_signed;
    logic            w_is_rem;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_take;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic            w_last;

    assign w_signed      = (op == ALU_DIV) || (op == ALU_REM);
    assign w_is_rem      = (op == ALU_REM) || (op == ALU_REMU);
    assign w_a_neg       = w_signed & a[XLEN-1];
    assign w_b_neg       = w_signed & b[XLEN-1];
    assign w_a_abs       = w_a_neg ? -a : a;
    assign w_b_abs       = w_b_neg ? -b : b;
    assign w_div_zero    = (b == '0);
    assign w_ovf         = w_signed && (a == DIV_OVF_Q) && (b == '1);
    assign w_special     = w_div_zero | w_ovf;
    assign w_special_res = w_div_zero ? (w_is_rem ? a : '1) : (w_is_rem ? '0 : DIV_OVF_Q);

    // One restoring step: a negative trial difference means the divisor did not fit
    assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_divisor};
    assign w_take    = ~w_diff[XLEN];
    assign w_rem_nxt = w_take ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_take};
    assign w_last    = (r_count == 5'd31);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= DIV_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: if (start) w_state_nxt = w_special ? DIV_DONE : DIV_RUN;
            DIV_RUN: begin
                if (!start)      w_state_nxt = DIV_IDLE;
                else if (w_last) w_state_nxt = DIV_DONE;
            end
            DIV_DONE: if (!start || ack) w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: if (start) begin
                    r_count   <= '0;
                    r_result  <= w_special_res;
                    r_rem     <= '0;
                    r_quo     <= w_a_abs;
                    r_divisor <= w_b_abs;
                    r_neg_q   <= w_a_neg ^ w_b_neg;
                    r_neg_r   <= w_a_neg;
                    r_is_rem  <= w_is_rem;
                end
                DIV_RUN: if (start) begin
                    r_rem   <= w_rem_nxt;
                    r_quo   <= w_quo_nxt;
                    r_count <= r_count + 5'd1;
                    if (w_last) begin
                        r_result <= r_is_rem ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                                             : (r_neg_q ? -w_quo_nxt : w_quo_nxt);
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by reset so the hazard unit sees no stall request while in reset
    assign busy   = reset_n && start && (r_state != DIV_DONE);
    assign done   = (r_state == DIV_DONE);
    assign result = r_result;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
//==============================================================================
// Module   : ex_stage
// Desc     : Execute stage: operand mux, ALU, multiplier, divider, EX/MEM register.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_stage
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            combined_stall,
    input  logic            ID_EX_enable_out,
    input  logic [XLEN-1:0] ID_EX_PC,
    input  logic [XLEN-1:0] ID_EX_Rs1Data,
    input  logic [XLEN-1:0] ID_EX_Rs2Data,
    input  logic [XLEN-1:0] ID_EX_Imm,
    input  logic [4:0]      ID_EX_ALUOp,
    input  logic            ID_EX_ALUSrc,
    input  logic [4:0]      ID_EX_Rd,
    input  logic            ID_EX_MemRead,
    input  logic            ID_EX_MemWrite,
    input  logic            ID_EX_MemToReg,
    input  logic            ID_EX_RegWrite,
    output logic [XLEN-1:0] EX_MEM_PC,
    output logic [XLEN-1:0] EX_MEM_ALUResult,
    output logic [XLEN-1:0] EX_MEM_WriteData,
    output logic [4:0]      EX_MEM_Rd,
    output logic            EX_MEM_MemRead,
    output logic            EX_MEM_MemWrite,
    output logic            EX_MEM_MemToReg,
    output logic            EX_MEM_RegWrite,
    output logic            EX_MEM_enable_out,
    output logic            ex_busy
);

    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_b;
    logic [4:0]        w_shamt;
    logic              w_mul_a_signed;
    logic              w_mul_b_signed;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_prod;
    logic              w_div_start;
    logic              w_div_ack;
    logic              w_div_busy;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_result;
    logic [XLEN-1:0]   w_result;

    assign w_a     = ID_EX_Rs1Data;
    assign w_b     = ID_EX_ALUSrc ? ID_EX_Imm : ID_EX_Rs2Data;
    assign w_shamt = w_b[4:0];

    // Single 64-bit multiplier; operand extension selects the signedness
    assign w_mul_a_signed = (ID_EX_ALUOp == ALU_MULH) || (ID_EX_ALUOp == ALU_MULHSU);
    assign w_mul_b_signed = (ID_EX_ALUOp == ALU_MULH);
    assign w_mul_a        = {{XLEN{w_mul_a_signed & w_a[XLEN-1]}}, w_a};
    assign w_mul_b        = {{XLEN{w_mul_b_signed & w_b[XLEN-1]}}, w_b};
    assign w_prod         = w_mul_a * w_mul_b;

    assign w_div_start = ID_EX_enable_out && is_div_op(ID_EX_ALUOp);
    assign w_div_ack   = ID_EX_enable_out && !combined_stall;

    ex_divider u_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_div_start),
        .op      (ID_EX_ALUOp),
        .a       (w_a),
        .b       (w_b),
        .ack     (w_div_ack),
        .busy    (w_div_busy),
        .done    (w_div_done),
        .result  (w_div_result)
    );

    assign ex_busy = w_div_busy;

    always_comb begin
        w_result = '0;
        case (ID_EX_ALUOp)
            ALU_ADD:    w_result = w_a + w_b;
            ALU_SUB:    w_result = w_a - w_b;
            ALU_SLL:    w_result = w_a << w_shamt;
            ALU_SLT:    w_result = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            ALU_SLTU:   w_result = {{(XLEN-1){1'b0}}, w_a < w_b};
            ALU_XOR:    w_result = w_a ^ w_b;
            ALU_SRL:    w_result = w_a >> w_shamt;
            ALU_SRA:    w_result = $signed(w_a) >>> w_shamt;
            ALU_OR:     w_result = w_a | w_b;
            ALU_AND:    w_result = w_a & w_b;
            ALU_PASSB:  w_result = w_b;
            ALU_MUL:    w_result = w_prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:
                        w_result = w_prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:
                        w_result = w_div_done ? w_div_result : '0;
            default:    w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || combined_stall) begin
            EX_MEM_PC         <= '0;
            EX_MEM_ALUResult  <= '0;
            EX_MEM_WriteData  <= '0;
            EX_MEM_Rd         <= '0;
            EX_MEM_MemRead    <= 1'b0;
            EX_MEM_MemWrite   <= 1'b0;
            EX_MEM_MemToReg   <= 1'b0;
            EX_MEM_RegWrite   <= 1'b0;
            EX_MEM_enable_out <= 1'b0;
        end else if (ID_EX_enable_out) begin
            EX_MEM_PC         <= ID_EX_PC;
            EX_MEM_ALUResult  <= w_result;
            EX_MEM_WriteData  <= ID_EX_Rs2Data;
            EX_MEM_Rd         <= ID_EX_Rd;
            EX_MEM_MemRead    <= ID_EX_MemRead;
            EX_MEM_MemWrite   <= ID_EX_MemWrite;
            EX_MEM_MemToReg   <= ID_EX_MemToReg;
            EX_MEM_RegWrite   <= ID_EX_RegWrite;
            EX_MEM_enable_out <= 1'b1;
        end else begin
            EX_MEM_enable_out <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
//==============================================================================
// Module   : tb_ex_stage
// Desc     : Self-checking bench for ex_stage: vector table, corner sequences, random.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tb_stall = 1'b0;
    logic        combined_stall;
    logic        ID_EX_enable_out = 1'b0;
    logic [31:0] ID_EX_PC = '0, ID_EX_Rs1Data = '0, ID_EX_Rs2Data = '0, ID_EX_Imm = '0;
    logic [4:0]  ID_EX_ALUOp = '0, ID_EX_Rd = '0;
    logic        ID_EX_ALUSrc = 1'b0;
    logic        ID_EX_MemRead = 1'b0, ID_EX_MemWrite = 1'b0, ID_EX_MemToReg = 1'b0, ID_EX_RegWrite = 1'b0;
    logic [31:0] EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData;
    logic [4:0]  EX_MEM_Rd;
    logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite;
    logic        EX_MEM_enable_out, ex_busy;

    always #5 clk = ~clk;

    // The bench stands in for the hazard unit
    assign combined_stall = ex_busy | tb_stall;

    ex_stage dut (
        .clk(clk), .reset_n(reset_n), .combined_stall(combined_stall),
        .ID_EX_enable_out(ID_EX_enable_out), .ID_EX_PC(ID_EX_PC),
        .ID_EX_Rs1Data(ID_EX_Rs1Data), .ID_EX_Rs2Data(ID_EX_Rs2Data), .ID_EX_Imm(ID_EX_Imm),
        .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_Rd(ID_EX_Rd),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_RegWrite(ID_EX_RegWrite),
        .EX_MEM_PC(EX_MEM_PC), .EX_MEM_ALUResult(EX_MEM_ALUResult),
        .EX_MEM_WriteData(EX_MEM_WriteData), .EX_MEM_Rd(EX_MEM_Rd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_MemToReg(EX_MEM_MemToReg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_enable_out(EX_MEM_enable_out), .ex_busy(ex_busy)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc, exp_wd;
    logic [8:0]  exp_ctl;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        alusrc;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model straight from the op definitions
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        int              sa, sb;
        sa = a;
        sb = b;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return sa >>> b[4:0];
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd11: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
            5'd12: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            5'd13: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            5'd14: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            5'd15: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            5'd16: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd17: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            5'd18: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic present(input logic [4:0] op, input logic [31:0] a, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic alusrc);
        ID_EX_ALUOp    = op;
        ID_EX_Rs1Data  = a;
        ID_EX_Rs2Data  = rs2;
        ID_EX_Imm      = imm;
        ID_EX_ALUSrc   = alusrc;
        ID_EX_PC       = $urandom;
        ID_EX_Rd       = 5'($urandom);
        {ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_RegWrite} = 4'($urandom);
        ID_EX_enable_out = 1'b1;
        exp_pc  = ID_EX_PC;
        exp_wd  = rs2;
        exp_ctl = {ID_EX_Rd, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_RegWrite};
    endtask

    // Counts edges until the EX/MEM register captures, and busy cycles on the way
    task automatic wait_capture(output int edges, output int busy_n, output bit ok);
        logic st;
        edges  = 0;
        busy_n = 0;
        ok     = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ex_busy) busy_n++;
            st = combined_stall;
            @(posedge clk);
            edges++;
            if (!st) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic check_capture(input string name, input logic [31:0] exp, input int exp_edges,
                                 input int exp_busy, input int edges, input int busy_n, input bit ok);
        chk({name, "_timeout"}, 64'(ok), 64'd1);
        chk({name, "_result"}, EX_MEM_ALUResult, exp);
        chk({name, "_valid"}, EX_MEM_enable_out, 1);
        chk({name, "_pc_wd"}, {EX_MEM_PC, EX_MEM_WriteData}, {exp_pc, exp_wd});
        chk({name, "_rd_ctl"}, {EX_MEM_Rd, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg,
                               EX_MEM_RegWrite}, exp_ctl);
        chk({name, "_latency"}, 64'(edges), 64'(exp_edges));
        chk({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] rs2, input logic [31:0] imm, input logic alusrc,
                          input logic [31:0] exp, input int exp_edges, input int exp_busy);
        int edges, busy_n;
        bit ok;
        present(op, a, rs2, imm, alusrc);
        wait_capture(edges, busy_n, ok);
        check_capture(name, exp, exp_edges, exp_busy, edges, busy_n, ok);
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, rs2, imm, b;
        logic        alusrc, is_div, special;
        bit          seen, ok;
        int          edges, busy_n;

        tbl[0]  = '{5'd0,  32'd5,          32'h1234_5678, 32'hFFFF_FFFD, 1'b1, 32'd2};
        tbl[1]  = '{5'd1,  32'd3,          32'd5,         32'h0,         1'b0, 32'hFFFF_FFFE};
        tbl[2]  = '{5'd2,  32'd1,          32'h23,        32'h0,         1'b0, 32'd8};
        tbl[3]  = '{5'd3,  32'hFFFF_FFFF,  32'd1,         32'h0,         1'b0, 32'd1};
        tbl[4]  = '{5'd4,  32'd1,          32'hFFFF_FFFF, 32'h0,         1'b0, 32'd1};
        tbl[5]  = '{5'd5,  32'hF0F0_F0F0,  32'hFF00_FF00, 32'h0,         1'b0, 32'h0FF0_0FF0};
        tbl[6]  = '{5'd6,  32'h8000_0000,  32'd4,         32'h0,         1'b0, 32'h0800_0000};
        tbl[7]  = '{5'd7,  32'h8000_0000,  32'h0,         32'd4,         1'b1, 32'hF800_0000};
        tbl[8]  = '{5'd8,  32'h0000_00F0,  32'h0000_0F00, 32'h0,         1'b0, 32'h0000_0FF0};
        tbl[9]  = '{5'd9,  32'hFF00_FF00,  32'h0FF0_0FF0, 32'h0,         1'b0, 32'h0F00_0F00};
        tbl[10] = '{5'd10, 32'hDEAD_BEEF,  32'h0,         32'h1234_5000, 1'b1, 32'h1234_5000};
        tbl[11] = '{5'd11, 32'h0001_0000,  32'h0001_0000, 32'h0,         1'b0, 32'h0};
        tbl[12] = '{5'd12, 32'h8000_0000,  32'h8000_0000, 32'h0,         1'b0, 32'h4000_0000};
        tbl[13] = '{5'd13, 32'hFFFF_FFFF,  32'd2,         32'h0,         1'b0, 32'hFFFF_FFFF};
        tbl[14] = '{5'd14, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         1'b0, 32'hFFFF_FFFE};
        tbl[15] = '{5'd19, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         1'b0, 32'h0};
        tbl[16] = '{5'd31, 32'd7,          32'd9,         32'h0,         1'b0, 32'h0};
        tbl[17] = '{5'd3,  32'd1,          32'hFFFF_FFFF, 32'h0,         1'b0, 32'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", EX_MEM_ALUResult, 0);
        chk("reset_valid", EX_MEM_enable_out, 0);
        chk("reset_pc_wd", {EX_MEM_PC, EX_MEM_WriteData}, 0);
        chk("reset_rd_ctl", {EX_MEM_Rd, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite}, 0);
        chk("reset_busy", ex_busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].rs2, tbl[i].imm,
                   tbl[i].alusrc, tbl[i].exp, 1, 0);

        // Normal and back-to-back divides, then the special cases
        run_op("div_m7_2",  5'd15, 32'hFFFF_FFF9, 32'd2, $urandom, 1'b0, 32'hFFFF_FFFD, 34, 33);
        run_op("rem_m7_2",  5'd17, 32'hFFFF_FFF9, 32'd2, $urandom, 1'b0, 32'hFFFF_FFFF, 34, 33);
        run_op("divu_by0",  5'd16, 32'd10, 32'd0, $urandom, 1'b0, 32'hFFFF_FFFF, 2, 1);
        run_op("rem_by0",   5'd17, 32'd10, 32'd0, $urandom, 1'b0, 32'd10, 2, 1);
        run_op("div_ovf",   5'd15, 32'h8000_0000, 32'hFFFF_FFFF, $urandom, 1'b0, 32'h8000_0000, 2, 1);
        run_op("rem_ovf",   5'd17, 32'h8000_0000, 32'hFFFF_FFFF, $urandom, 1'b0, 32'd0, 2, 1);

        // External stall held through DONE: bubbles, result held, then latched
        tb_stall = 1'b1;
        present(5'd15, 32'd100, 32'd7, 32'h0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (!ex_busy) seen = 1'b1;
        end
        chk("stall_reach_done", 64'(seen), 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_bubble_result", {EX_MEM_ALUResult, EX_MEM_PC}, 0);
            chk("stall_bubble_ctl", {EX_MEM_enable_out, EX_MEM_Rd, EX_MEM_WriteData, EX_MEM_MemRead,
                                     EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite}, 0);
            chk("stall_done_not_busy", ex_busy, 0);
        end
        tb_stall = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_release_valid", EX_MEM_enable_out, 1);
        chk("stall_release_result", EX_MEM_ALUResult, 32'd14);

        // Abort: enable dropped mid-run, the next divide must start from scratch
        present(5'd16, 32'd1000, 32'd3, 32'h0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        ID_EX_enable_out = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", EX_MEM_enable_out, 0);
            chk("abort_not_busy", ex_busy, 0);
        end
        run_op("after_abort", 5'd16, 32'd100, 32'd7, 32'h0, 1'b0, 32'd14, 34, 33);

        // Hold when idle, then asynchronous clear of a held result
        run_op("hold_add", 5'd0, 32'h11, 32'h22, 32'h0, 1'b0, 32'h33, 1, 0);
        ID_EX_enable_out = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_result", EX_MEM_ALUResult, 32'h33);
        chk("hold_valid", EX_MEM_enable_out, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_result", EX_MEM_ALUResult, 0);
        chk("async_rst_pc_wd", {EX_MEM_PC, EX_MEM_WriteData}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset in RUN cycle 10, then a fresh DIV 100/7 after release
        present(5'd15, 32'd50, 32'd3, 32'h0, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_run_busy", ex_busy, 0);
        chk("rst_run_outputs", {EX_MEM_enable_out, EX_MEM_ALUResult, EX_MEM_Rd}, 0);
        present(5'd15, 32'd100, 32'd7, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_capture(edges, busy_n, ok);
        check_capture("rst_then_div", 32'd14, 34, 33, edges, busy_n, ok);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            op      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(15, 18)) : 5'($urandom_range(0, 31));
            a       = pick();
            rs2     = pick();
            imm     = pick();
            alusrc  = 1'($urandom_range(0, 1));
            b       = alusrc ? imm : rs2;
            is_div  = (op >= 5'd15) && (op <= 5'd18);
            special = is_div && ((b == 0) ||
                      ((op == 5'd15 || op == 5'd17) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            run_op($sformatf("rnd%0d_op%0d", n, op), op, a, rs2, imm, alusrc, model(op, a, b),
                   !is_div ? 1 : (special ? 2 : 34), !is_div ? 0 : (special ? 1 : 33));
        end
        ID_EX_enable_out = 1'b0;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage core, directly upstream of the memory stage. Takes decoded operands and control from the ID/EX boundary, computes the ALU or multiply/divide result, and registers it into the EX/MEM pipeline register consumed by the memory stage. Single-cycle for ALU and multiply ops; an iterative radix-2 divider covers DIV/DIVU/REM/REMU and requests a pipeline stall while it runs.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- combined_stall  in  1  global stall from the hazard unit; includes ex_busy
- ID_EX_enable_out  in  1  ID/EX entry valid
- ID_EX_PC  in  32  instruction PC
- ID_EX_Rs1Data, ID_EX_Rs2Data  in  32  operands, already forwarded
- ID_EX_Imm  in  32  sign-extended immediate
- ID_EX_ALUOp  in  5  operation code (shared package)
- ID_EX_ALUSrc  in  1  1: operand B = Imm, 0: Rs2Data
- ID_EX_Rd  in  5  destination register
- ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_RegWrite  in  1 each  control, passed through
- EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData  out  32 each  registered; WriteData = Rs2Data
- EX_MEM_Rd  out  5  registered
- EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite  out  1 each  registered
- EX_MEM_enable_out  out  1  registered valid to the memory stage
- ex_busy  out  1  combinational stall request to the hazard unit

## Operation
- A = Rs1Data; B = ALUSrc ? Imm : Rs2Data.
- Ops: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10 (LUI), MUL 11, MULH 12, MULHSU 13, MULHU 14, DIV 15, DIVU 16, REM 17, REMU 18. Codes 19–31 give result 0.
- Shift amount = B[4:0]. SLT/SLTU produce 0 or 1. All arithmetic wraps mod 2^32. MUL gives the low 32 bits of the 64-bit product; MULH* give the high 32 bits with the stated signedness. Multiplies are single-cycle.
- Divider FSM states: IDLE, RUN, DONE.
  - IDLE: valid div op present -> ex_busy=1. Special case (divisor 0, or signed 0x80000000 / -1) -> DONE with fixed result. Otherwise -> RUN with count=0; signed ops first take absolute values.
  - RUN: one restoring step per cycle, ex_busy=1. After 32 steps -> DONE. Signs are fixed on entry to DONE: quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - DONE: ex_busy=0, result held. Goes to IDLE on the cycle the result is latched (enable && !combined_stall). Otherwise holds.
  - ID_EX_enable_out low in RUN or DONE aborts to IDLE with no output update.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend. Overflow: quotient 0x80000000, remainder 0.
- EX/MEM register update, priority order:
  - reset: all EX_MEM outputs 0.
  - combined_stall=1: bubble. All EX_MEM outputs 0, enable_out 0.
  - ID_EX_enable_out=1: capture result and pass-through fields, enable_out 1.
  - otherwise: enable_out 0; other outputs hold.
- ex_busy = ID_EX_enable_out && div op && state != DONE.

## Timing
- ALU and multiply ops: 1 cycle, with EX_MEM valid after the next edge.
- Normal divide: presented in cycle 0. Cycle 0 is IDLE, cycles 1–32 are RUN, cycle 33 is DONE with ex_busy low. EX_MEM is valid after the 34th edge.
- Special-case divide: EX_MEM is valid after the 2nd edge.
- The ID/EX inputs stay stable while ex_busy=1, because the hazard unit holds upstream.
- Reset mid-divide: state becomes IDLE and count becomes 0 asynchronously; the partial result is discarded.
- Back-to-back divides: the second divide starts in IDLE on the cycle after the first is latched.

## Structure
- Shared package core_pkg holds:
  - the ALUOp localparams listed above;
  - the divider state encoding (2 bits);
  - DIV_OVF_Q = 32'h80000000.
- Sub-module ex_divider holds the FSM, the iteration counter, the remainder/quotient shift registers and the sign fix-up. Its handshake is start/op/a/b in and busy/done/result out, plus an ack input.
- ex_stage holds the operand mux, the combinational ALU and multiplier, the result mux and the EX/MEM register.

## Test plan
- ADD: A=5, B=Imm=-3, ALUSrc=1 -> EX_MEM_ALUResult=2, enable_out=1 after one edge, Rd/RegWrite passed through.
- SRA: 0x80000000 with B=4 -> 0xF8000000. SLTU with A=1, B=0xFFFFFFFF -> 1. MULH 0x80000000 x 0x80000000 -> 0x40000000.
- DIV -7/2:
  - ex_busy high for exactly 33 cycles;
  - EX_MEM_ALUResult = 0xFFFFFFFD after the 34th edge;
  - REM of the same operands -> 0xFFFFFFFF.
- Divide special cases:
  - DIVU 10/0 -> 0xFFFFFFFF, with ex_busy high for 1 cycle;
  - REM 10/0 -> 10;
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- Stall and abort:
  - combined_stall forced high during DONE -> EX_MEM bubbles (all 0) and the result is held;
  - releasing the stall latches the result.
  - Dropping ID_EX_enable_out during RUN -> FSM returns to IDLE with no valid output.
- Reset: assert reset_n low in RUN cycle 10 -> all EX_MEM outputs 0 immediately, ex_busy 0. After release, a new DIV 100/7 -> 14.
